// File: rtl/bus_slave_mem_if.sv
// Request/grant bus between a master and bus_slave_mem.
// The err signal exists only when BUS_SLAVE_RANGE_CHK_EN is defined.
interface bus_slave_mem_if;
  logic        req;
  logic        wr_en;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        gnt;
  logic [31:0] rdata;
`ifdef BUS_SLAVE_RANGE_CHK_EN
  logic        err;

  modport master (output req, wr_en, addr, wdata, input gnt, rdata, err);
  modport slave  (input req, wr_en, addr, wdata, output gnt, rdata, err);
`else
  modport master (output req, wr_en, addr, wdata, input gnt, rdata);
  modport slave  (input req, wr_en, addr, wdata, output gnt, rdata);
`endif
endinterface

// File: rtl/bus_slave_mem.sv
// Word-addressed memory slave with a programmable wait-state handshake.
// Optional feature macro: BUS_SLAVE_RANGE_CHK_EN (out-of-range detection with err flag).
module bus_slave_mem #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            rst_n,
  bus_slave_mem_if.slave bus
);

  localparam int         AW        = $clog2(DEPTH);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 32'sd0);
  localparam logic [3:0] WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [3:0]    cnt_r;
  logic [3:0]    cnt_next_s;
  logic          gnt_r;
  logic [31:0]   rdata_r;
  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] idx_s;
  logic          in_range_s;
  logic          enter_grant_s;

  assign idx_s = bus.addr[AW-1:0];

`ifdef BUS_SLAVE_RANGE_CHK_EN
  logic err_r;
  assign in_range_s = ({1'b0, bus.addr} < 9'(DEPTH));
  assign bus.err    = err_r;
`else
  // Upper address bits are intentionally ignored: addresses wrap modulo DEPTH.
  logic unused_addr_s;
  assign unused_addr_s = ^bus.addr;
  assign in_range_s    = 1'b1;
`endif

  // The access happens on the same edge that moves the FSM into GRANT.
  assign enter_grant_s = (state_next_s == GRANT);
  assign bus.gnt       = gnt_r;
  assign bus.rdata     = rdata_r;

  // Next-state and wait-counter logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.req) begin
          if (ZERO_WAIT) begin
            state_next_s = GRANT;
          end else begin
            state_next_s = WAIT;
            cnt_next_s   = WAIT_LOAD;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (!bus.req) begin
          state_next_s = IDLE;
          cnt_next_s   = 4'd0;
        end else if (cnt_r == 4'd0) begin
          state_next_s = GRANT;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      GRANT: begin
        if (bus.req) begin
          state_next_s = DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      DONE: begin
        if (bus.req) begin
          state_next_s = DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // State, counter and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      gnt_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
`ifdef BUS_SLAVE_RANGE_CHK_EN
      err_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      gnt_r   <= enter_grant_s;
      if (enter_grant_s && !bus.wr_en) begin
        rdata_r <= in_range_s ? mem_r[idx_s] : 32'hDEAD_BEEF;
      end
`ifdef BUS_SLAVE_RANGE_CHK_EN
      err_r   <= enter_grant_s && !in_range_s;
`endif
    end
  end

  // Storage array; never reset, and writes are blocked while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n && enter_grant_s && bus.wr_en && in_range_s) begin
      mem_r[idx_s] <= bus.wdata;
    end
  end

endmodule

// File: tb/tb_bus_slave_mem.sv
// Self-checking bench for bus_slave_mem: three instances (wait 2 / wait 0 / wait 4)
// driven by a vector table, corner-case sequences and a randomized model-checked phase.
module tb_bus_slave_mem;

`ifdef BUS_SLAVE_RANGE_CHK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_v   [3];
  logic        wr_v    [3];
  logic [7:0]  addr_v  [3];
  logic [31:0] wdata_v [3];
  logic        gnt_v   [3];
  logic [31:0] rdata_v [3];
  logic        err_v   [3];

  int checks   = 0;
  int failures = 0;

  // Reference model: per-instance word store, written flags and last read value.
  logic [31:0] mm  [3][256];
  bit          mv  [3][256];
  logic [31:0] mrd [3];

  typedef struct {
    int          d;
    bit          wr;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          er;
  } vec_t;
  vec_t tbl [15];

  bus_slave_mem_if bus0 ();
  bus_slave_mem_if bus1 ();
  bus_slave_mem_if bus2 ();

  bus_slave_mem #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  bus_slave_mem #(.DEPTH(64),  .WAIT_CYCLES(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  bus_slave_mem #(.DEPTH(16),  .WAIT_CYCLES(4)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.req = req_v[0];  assign bus0.wr_en = wr_v[0];
  assign bus0.addr = addr_v[0]; assign bus0.wdata = wdata_v[0];
  assign bus1.req = req_v[1];  assign bus1.wr_en = wr_v[1];
  assign bus1.addr = addr_v[1]; assign bus1.wdata = wdata_v[1];
  assign bus2.req = req_v[2];  assign bus2.wr_en = wr_v[2];
  assign bus2.addr = addr_v[2]; assign bus2.wdata = wdata_v[2];
  assign gnt_v[0] = bus0.gnt;  assign rdata_v[0] = bus0.rdata;
  assign gnt_v[1] = bus1.gnt;  assign rdata_v[1] = bus1.rdata;
  assign gnt_v[2] = bus2.gnt;  assign rdata_v[2] = bus2.rdata;
`ifdef BUS_SLAVE_RANGE_CHK_EN
  assign err_v[0] = bus0.err;  assign err_v[1] = bus1.err;  assign err_v[2] = bus2.err;
`else
  assign err_v[0] = 1'b0;      assign err_v[1] = 1'b0;      assign err_v[2] = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dep(input int d);
    case (d)
      0:       return 256;
      1:       return 64;
      default: return 16;
    endcase
  endfunction

  function automatic int wt(input int d);
    case (d)
      0:       return 2;
      1:       return 0;
      default: return 4;
    endcase
  endfunction

  function automatic bit in_rng(input int d, input logic [7:0] a);
    return (int'(a) < dep(d)) || !RC;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete handshake: raise req, wait (bounded) for gnt, drop req, observe the next cycle.
  task automatic do_txn(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output logic tail);
    lat = -1;
    rd  = 32'h0;
    er  = 1'b0;
    @(negedge clk);
    req_v[d] = 1'b1; wr_v[d] = wr; addr_v[d] = a; wdata_v[d] = wd;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (gnt_v[d]) begin
        lat = c; rd = rdata_v[d]; er = err_v[d];
        break;
      end
    end
    @(negedge clk);
    req_v[d] = 1'b0; wr_v[d] = 1'b0;
    @(posedge clk); #1;
    tail = gnt_v[d] | err_v[d];
  endtask

  task automatic run_txn(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input bit exp_er, input string nm);
    int lat; logic [31:0] rd; logic er; logic tail;
    do_txn(d, wr, a, wd, lat, rd, er, tail);
    check({nm, ".latency"}, 32'(lat), 32'(wt(d) + 1));
    check({nm, ".rdata"}, rd, exp_rd);
    check({nm, ".err"}, {31'd0, er}, {31'd0, exp_er});
    check({nm, ".gnt_one_cycle"}, {31'd0, tail}, 32'd0);
  endtask

  task automatic model_update(input int d, input bit wr, input logic [7:0] a,
                              input logic [31:0] wd, input logic [31:0] rd);
    int ix;
    ix = int'(a) % dep(d);
    if (wr && in_rng(d, a)) begin
      mm[d][ix] = wd;
      mv[d][ix] = 1'b1;
    end
    if (!wr) mrd[d] = rd;
  endtask

  // Transaction whose expectations come entirely from the reference model.
  task automatic mtxn(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input string nm);
    logic [31:0] exp_rd;
    int ix;
    ix = int'(a) % dep(d);
    if (wr)                exp_rd = mrd[d];
    else if (in_rng(d, a)) exp_rd = mm[d][ix];
    else                   exp_rd = 32'hDEADBEEF;
    run_txn(d, wr, a, wd, exp_rd, !in_rng(d, a), nm);
    model_update(d, wr, a, wd, exp_rd);
  endtask

  initial begin
    int pulses; int first; logic [7:0] a; bit wr; int d; int ix;
    for (int i = 0; i < 3; i++) begin
      req_v[i] = 1'b0; wr_v[i] = 1'b0; addr_v[i] = 8'h0; wdata_v[i] = 32'h0;
      mrd[i] = 32'h0;
      for (int j = 0; j < 256; j++) mv[i][j] = 1'b0;
    end

    // Reset takes effect without any clock edge.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset.gnt%0d", i), {31'd0, gnt_v[i]}, 32'd0);
      check($sformatf("reset.rdata%0d", i), rdata_v[i], 32'h0);
      check($sformatf("reset.err%0d", i), {31'd0, err_v[i]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    tbl[0]  = '{0, 1'b1, 8'h10, 32'hCAFEF00D, 32'h0,        1'b0};
    tbl[1]  = '{0, 1'b0, 8'h10, 32'h0,        32'hCAFEF00D, 1'b0};
    tbl[2]  = '{0, 1'b1, 8'h11, 32'h12345678, 32'hCAFEF00D, 1'b0};
    tbl[3]  = '{0, 1'b0, 8'h11, 32'h0,        32'h12345678, 1'b0};
    tbl[4]  = '{1, 1'b1, 8'h01, 32'h00000001, 32'h0,        1'b0};
    tbl[5]  = '{1, 1'b0, 8'h01, 32'h0,        32'h00000001, 1'b0};
    tbl[6]  = '{1, 1'b1, 8'h00, 32'h11111111, 32'h00000001, 1'b0};
    tbl[7]  = '{1, 1'b1, 8'h80, 32'h22222222, 32'h00000001, RC};
    tbl[8]  = '{1, 1'b0, 8'h80, 32'h0, RC ? 32'hDEADBEEF : 32'h22222222, RC};
    tbl[9]  = '{1, 1'b0, 8'h00, 32'h0, RC ? 32'h11111111 : 32'h22222222, 1'b0};
    tbl[10] = '{1, 1'b0, 8'h41, 32'h0, RC ? 32'hDEADBEEF : 32'h00000001, RC};
    tbl[11] = '{2, 1'b1, 8'h05, 32'hA5A5A5A5, 32'h0,        1'b0};
    tbl[12] = '{2, 1'b0, 8'h05, 32'h0,        32'hA5A5A5A5, 1'b0};
    tbl[13] = '{2, 1'b0, 8'h15, 32'h0, RC ? 32'hDEADBEEF : 32'hA5A5A5A5, RC};
    tbl[14] = '{2, 1'b1, 8'h07, 32'h0BADF00D, tbl[13].rd,   1'b0};

    for (int i = 0; i < 15; i++) begin
      run_txn(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].er,
              $sformatf("vec%0d", i));
      model_update(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].rd);
    end

    // Abort during WAIT: one cycle of req, then nothing must be granted or written.
    @(negedge clk);
    req_v[2] = 1'b1; wr_v[2] = 1'b1; addr_v[2] = 8'h07; wdata_v[2] = 32'hFFFFFFFF;
    @(negedge clk);
    req_v[2] = 1'b0; wr_v[2] = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (gnt_v[2]) pulses++;
    end
    check("abort.no_gnt", 32'(pulses), 32'd0);
    mtxn(2, 1'b0, 8'h07, 32'h0, "abort.readback");

    // Held request: exactly one gnt pulse, then a fresh request still works.
    @(negedge clk);
    req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 8'h10;
    pulses = 0; first = -1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (gnt_v[0]) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    check("held.pulses", 32'(pulses), 32'd1);
    check("held.first_gnt", 32'(first), 32'd3);
    check("held.rdata", rdata_v[0], mm[0][16]);
    mrd[0] = mm[0][16];
    @(negedge clk);
    req_v[0] = 1'b0;
    @(posedge clk); #1;
    mtxn(0, 1'b0, 8'h11, 32'h0, "held.next");

    // Reset in the middle of a write's wait phase.
    mtxn(0, 1'b1, 8'h20, 32'h20202020, "rst.prewrite");
    @(negedge clk);
    req_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 8'h20; wdata_v[0] = 32'hDEAD0020;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst.mid_gnt", {31'd0, gnt_v[0]}, 32'd0);
    check("rst.mid_rdata", rdata_v[0], 32'h0);
    check("rst.mid_rdata_other", rdata_v[1], 32'h0);
    req_v[0] = 1'b0; wr_v[0] = 1'b0;
    for (int i = 0; i < 3; i++) mrd[i] = 32'h0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    mtxn(0, 1'b0, 8'h20, 32'h0, "rst.readback");

    // Randomized transactions against the model.
    for (int i = 0; i < 90; i++) begin
      d  = i % 3;
      a  = (d == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
      wr = 1'($urandom_range(0, 1));
      ix = int'(a) % dep(d);
      if (!wr && in_rng(d, a) && !mv[d][ix]) wr = 1'b1;
      mtxn(d, wr, a, $urandom, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
